lfsr_rr_server: RTL and testbench

Shares one 4-bit Fibonacci LFSR (x^4+x^3+1, period 15) between N_REQ requesters using round-robin arbitration. On a grant, the block advances the LFSR STEPS times so that successive consumers never receive adjacent states, then presents the value with a one-cycle grant pulse. It also provides a software seed-load path with lock-up protection. It sits between the shared random source and the LED/pattern consumers in the top level.

---
 rtl/lfsr_rr_server.sv | 139 +++++++++++++
 tb/tb_lfsr_rr_server.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_server.sv
// Round-robin server for one shared 4-bit LFSR (x^4+x^3+1). Each grant advances
// the LFSR STEPS times, then presents the value alongside a one-cycle one-hot grant.
module lfsr_rr_server #(
  parameter int         N_REQ = 4,
  parameter int         STEPS = 4,
  parameter logic [3:0] SEED  = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [3:0]       seed_val,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       rnd,
  output logic             busy
);

  localparam int         PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_lfsr;
  logic [3:0]       r_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_win;
  logic [N_REQ-1:0] r_gnt;
  logic [3:0]       r_rnd;
  logic             r_busy;

  logic [PTR_W-1:0] w_win;
  logic [3:0]       w_seed;
  logic [3:0]       w_lfsr_shift;
  logic [N_REQ-1:0] w_onehot;
  logic             w_any_req;
  logic             w_last_step;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[2] ^ s[3]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the reset seed.
  function automatic logic [3:0] seed_fix(input logic [3:0] v);
    return (v == 4'd0) ? SEED : v;
  endfunction

  // Walk from farthest to nearest so the last hit is the first set bit after p.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    int               m;
    win = p;
    for (int k = N_REQ; k >= 1; k--) begin
      m   = (int'(p) + k) % N_REQ;
      idx = PTR_W'(m);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign w_any_req    = |req;
  assign w_win        = rr_pick(req, r_ptr);
  assign w_seed       = seed_fix(seed_val);
  assign w_lfsr_shift = lfsr_next(r_lfsr);
  assign w_onehot     = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
  assign w_last_step  = (r_cnt == LAST_STEP);

  // Control: state, step counter, latched winner and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_win   <= '0;
      r_ptr   <= PTR_W'(N_REQ - 1);
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_win   <= w_win;
            r_cnt   <= 4'd0;
            r_state <= S_STEP;
            r_busy  <= 1'b1;
          end
        end
        S_STEP: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last_step) r_state <= S_SERVE;
        end
        S_SERVE: begin
          r_ptr   <= r_win;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // LFSR: seed loads only while idle, shifts only while stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else begin
      if (r_state == S_IDLE) begin
        if (seed_load) r_lfsr <= w_seed;
      end else if (r_state == S_STEP) begin
        r_lfsr <= w_lfsr_shift;
      end
    end
  end

  // Outputs are registered so that they land exactly in the SERVE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt <= '0;
      r_rnd <= 4'd0;
    end else begin
      r_gnt <= '0;
      r_rnd <= 4'd0;
      if ((r_state == S_STEP) && w_last_step) begin
        r_gnt <= w_onehot;
        r_rnd <= w_lfsr_shift;
      end
    end
  end

  assign gnt  = r_gnt;
  assign rnd  = r_rnd;
  assign busy = r_busy;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Randomised and directed bench for lfsr_rr_server against a cycle-count model.
module tb_lfsr_rr_server;

  localparam int         N    = 4;
  localparam int         ST   = 4;
  localparam logic [3:0] SEED = 4'b1111;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic [N-1:0] req       = '0;
  logic         seed_load = 1'b0;
  logic [3:0]   seed_val  = 4'd0;
  logic [N-1:0] gnt;
  logic [3:0]   rnd;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  lfsr_rr_server #(.N_REQ(N), .STEPS(ST), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_val(seed_val),
    .gnt(gnt), .rnd(rnd), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: cycles left until idle, and the grant outcome computed up front.
  int         m_left = 0;
  int         m_ptr  = N - 1;
  int         m_win  = 0;
  logic [3:0] m_lfsr = SEED;
  logic [3:0] m_rnd  = 4'd0;

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  function automatic logic [3:0] advance(input logic [3:0] s, input int n);
    logic [3:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[2:0], v[3] ^ v[2]};
    return v;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_left = 0; m_ptr = N - 1; m_win = 0; m_lfsr = SEED; m_rnd = 4'd0;
    end else if (m_left == 0) begin
      if (seed_load) m_lfsr = (seed_val == 4'd0) ? SEED : seed_val;
      if (req != '0) begin
        m_win  = rr_model(req, m_ptr);
        m_lfsr = advance(m_lfsr, ST);
        m_rnd  = m_lfsr;
        m_left = ST + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_ptr = m_win;
    end
  end

  initial forever begin
    int exp_g;
    @(negedge clk);
    exp_g = (m_left == 1) ? (1 << m_win) : 0;
    chk("gnt", int'(gnt), exp_g);
    chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
    chk("onehot0", int'($onehot0(gnt)), 1);
    if (exp_g != 0) chk("rnd", int'(rnd), int'(m_rnd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output logic [N-1:0] g, output logic [3:0] r,
                            output int lat, output int bc);
    g = '0; r = 4'd0; lat = 0; bc = 0;
    while (lat < limit) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (gnt != '0) begin
        g = gnt; r = rnd;
        return;
      end
    end
    chk("grant_timeout", 0, 1);
  endtask

  initial begin
    logic [N-1:0] g;
    logic [3:0]   r;
    int           lat, bc, seen, distinct;
    logic [3:0]   tab[4];
    logic [3:0]   hist[16];

    tab[0] = 4'b0001; tab[1] = 4'b0011; tab[2] = 4'b0101; tab[3] = 4'b1110;

    // Reset state
    repeat (3) tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rnd", int'(rnd), 0);
    rst = 1'b1;

    // Single requester from reset
    req = 4'b0001;
    wait_grant(20, g, r, lat, bc);
    chk("t1_gnt", int'(g), 1);
    chk("t1_rnd", int'(r), 1);
    chk("t1_lat", lat, 6);
    chk("t1_busy_cycles", bc, 5);
    tick(); req = '0;

    // All four held from reset: rotation and spacing
    rst = 1'b0; tick(); rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(20, g, r, lat, bc);
      chk($sformatf("t2_gnt%0d", i), int'(g), 1 << (i % 4));
      chk($sformatf("t2_lat%0d", i), lat, 6);
      if (i < 4) chk($sformatf("t2_rnd%0d", i), int'(r), int'(tab[i]));
    end
    tick(); req = '0;

    // Seed load of 0001, then a zero seed loaded together with a request
    seed_load = 1'b1; seed_val = 4'b0001;
    tick(); seed_load = 1'b0; req = 4'b0100;
    wait_grant(20, g, r, lat, bc);
    chk("t3a_gnt", int'(g), 4);
    chk("t3a_rnd", int'(r), 4'b0011);
    tick(); req = 4'b0100; seed_load = 1'b1; seed_val = 4'b0000;
    tick(); seed_load = 1'b0;
    wait_grant(20, g, r, lat, bc);
    chk("t3b_gnt", int'(g), 4);
    chk("t3b_rnd", int'(r), 4'b0001);
    chk("t3b_lat", lat, 5);
    tick(); req = '0;

    // Seed load during STEP is ignored; grant is a single-cycle pulse
    req = 4'b0100;
    tick(); tick();
    seed_load = 1'b1; seed_val = 4'b1010;
    tick(); seed_load = 1'b0;
    wait_grant(20, g, r, lat, bc);
    chk("t4_gnt", int'(g), 4);
    chk("t4_rnd", int'(r), 4'b0011);
    @(negedge clk);
    chk("t4_width", int'(gnt), 0);
    req = '0;
    tick();

    // Reset during the second STEP cycle
    req = 4'b0010;
    tick(); tick();
    rst = 1'b0; req = '0;
    @(negedge clk);
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    tick(); rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != '0) seen++;
    end
    chk("t5_no_grant", seen, 0);
    tick(); req = 4'b0010;
    wait_grant(20, g, r, lat, bc);
    chk("t5_gnt", int'(g), 2);
    chk("t5_rnd", int'(r), 4'b0001);
    chk("t5_lat", lat, 6);
    tick(); req = '0;

    // Lone requester re-granted 16 times: period 15, never zero
    req = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      wait_grant(20, g, r, lat, bc);
      hist[i] = r;
      chk($sformatf("t6_gnt%0d", i), int'(g), 8);
      chk($sformatf("t6_nonzero%0d", i), (r != 4'd0) ? 1 : 0, 1);
    end
    tick(); req = '0;
    chk("t6_period", int'(hist[15]), int'(hist[0]));
    distinct = 0;
    for (int i = 0; i < 15; i++) begin
      seen = 0;
      for (int j = 0; j < i; j++) if (hist[j] == hist[i]) seen = 1;
      if (seen == 0) distinct++;
    end
    chk("t6_distinct", distinct, 15);

    // Random traffic, seed loads and occasional resets against the model
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      req       = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      seed_load = ($urandom_range(0, 5) == 0);
      seed_val  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
    end
    tick();
    rst = 1'b1; req = '0; seed_load = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
